regfile_wb_arbiter: RTL

//  Shares the register file's single write port between N_REQ writeback requesters
//  (e.g. ALU result, load data, HI/LO move). Uses round-robin arbitration, a valid/ready

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr_picker.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : regfile_pkg                                             |
// | Brief  : Shared register-file constants for the writeback path.  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rr_picker                                               |
// | Brief  : Rotating-priority encoder. Returns the first set request |
// |          at or after i_ptr, wrapping modulo N.                   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_any,
  output logic [PTR_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot
);

  // Scan from farthest to nearest offset so the nearest hit is the last write.
  always_comb begin : p_pick
    int j;
    o_any    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_any = 1'b1;
        o_idx = PTR_W'(j);
      end
    end
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = o_any && (o_idx == PTR_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : regfile_wb_arbiter                                      |
// | Brief  : Round-robin arbiter sharing the register file write port|
// |          between N_REQ writeback requesters via one staging slot.|
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hold,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_reg,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    regWrite,
  output logic [ADDR_W-1:0]       writeRegister,
  output logic [DATA_W-1:0]       writeData,
  output logic                    pend_valid,
  output logic [ADDR_W-1:0]       pend_reg
);

  localparam int PTR_W = $clog2(N_REQ);

  logic              r_stg_valid;
  logic [ADDR_W-1:0] r_stg_reg;
  logic [DATA_W-1:0] r_stg_data;
  logic [PTR_W-1:0]  r_rr_ptr;

  logic              w_drain;
  logic              w_can_acc;
  logic [N_REQ-1:0]  w_req_masked;
  logic              w_any;
  logic [PTR_W-1:0]  w_idx;
  logic [N_REQ-1:0]  w_onehot;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic [PTR_W-1:0]  w_next_ptr;

  // The slot can take a new entry when empty or when it empties this cycle.
  always_comb begin
    w_drain      = r_stg_valid & ~hold;
    w_can_acc    = (~r_stg_valid | w_drain) & ~reset;
    w_req_masked = req_valid & {N_REQ{w_can_acc}};
  end

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req    (w_req_masked),
    .i_ptr    (r_rr_ptr),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // Select the granted requester's payload and the pointer just past it.
  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_onehot[i]) begin
        w_sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    w_next_ptr = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
  end

  // Staging slot and round-robin pointer; a grant overrides a same-edge drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_reg   <= '0;
      r_stg_data  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_any) begin
      r_stg_valid <= 1'b1;
      r_stg_reg   <= w_sel_reg;
      r_stg_data  <= w_sel_data;
      r_rr_ptr    <= w_next_ptr;
    end else if (w_drain) begin
      r_stg_valid <= 1'b0;
    end
  end

  // Write-port and hazard outputs; all forced quiet while reset is high.
  always_comb begin
    req_ready     = w_onehot;
    regWrite      = w_drain & (r_stg_reg != ADDR_W'(REG_ZERO)) & ~reset;
    writeRegister = reset ? '0 : r_stg_reg;
    writeData     = reset ? '0 : r_stg_data;
    pend_valid    = r_stg_valid & ~reset;
    pend_reg      = pend_valid ? r_stg_reg : '0;
  end

endmodule
`default_nettype wire
